// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdderOneBit.sv
// One-bit full adder shared across the codebase.
module FullAdderOneBit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Plain combinational sum and majority carry
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit position per clock, LSB first, through a single
// full adder. A result is published on sum/c_out together with a one-cycle
// done pulse, WIDTH edges after the accept edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Counter is wide enough to hold WIDTH, so it never wraps mid-operation.
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_shift;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fa_sum;
  logic               fa_cout;

  // New sum bit enters at the MSB end; after WIDTH shifts the first bit
  // computed has reached bit 0. Written as a shift of the concatenation so
  // WIDTH=1 needs no special case.
  assign res_shift = WIDTH'({fa_sum, res_q} >> 1);

  FullAdderOneBit u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // Control FSM and datapath registers, with busy/done as registered outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          res_q   <= res_shift;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            sum     <= res_shift;
            c_out   <= fa_cout;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 1-bit instance for the full truth table. Expected results come from
// an arithmetic model pushed onto a scoreboard at each accept edge.
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  exp_t sb8[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] bb_a [4] = '{8'h01, 8'h80, 8'hAA, 8'h00};
  logic [7:0] bb_b [4] = '{8'h02, 8'h80, 8'h55, 8'h00};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c_in  (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .c_out (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; sampling and driving both happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
    logic [32:0] t;
    logic [32:0] m;
    exp_t        e;
    t      = {1'b0, a} + {1'b0, b} + 33'(c);
    m      = (33'd1 << w) - 33'd1;
    e.sum  = 32'(t & m);
    e.cout = t[w];
    return e;
  endfunction

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8     = a;
    b8     = b;
    cin8   = c;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    sb8.push_back(model(8, {24'd0, a}, {24'd0, b}, c));
    check("accept_busy", busy8, 1);
  endtask

  // elapsed: RUN edges the caller already stepped through after the accept.
  task automatic finish_op8(input string tag, input int elapsed);
    int   lat;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    lat      = elapsed;
    busy_cnt = 1 + elapsed;
    seen     = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (busy8) busy_cnt++;
      if (done8) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      if (sb8.size() > 0) e = sb8.pop_front();
    end else begin
      // done becomes visible after edge 8, i.e. it is sampled by the 9th edge
      // counting the accept edge itself
      check({tag, "_latency"}, lat, 8);
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        check({tag, "_sum"}, sum8, e.sum);
        check({tag, "_cout"}, cout8, e.cout);
      end else begin
        check({tag, "_scoreboard_empty"}, 0, 1);
      end
      tick();
      check({tag, "_done_one_cycle"}, done8, 0);
      check({tag, "_busy_drop"}, busy8, 0);
      check({tag, "_busy_cycles"}, busy_cnt, 9);
    end
  endtask

  initial begin
    int   acc[3];
    int   don[3];
    int   n_acc;
    int   n_done;
    bit   prev_busy;
    bit   rose;
    exp_t ex;

    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick();
    tick();

    // Reset state of both instances
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8",  sum8,  0);
    check("rst_cout8", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_sum1",  sum1,  0);
    check("rst_cout1", cout1, 0);
    rst_n = 1'b1;
    tick();

    // Basic carry ripple through the low nibble
    start_op8(8'h0F, 8'h01, 1'b0);
    finish_op8("op_0f_01", 0);

    // Full overflow and all-ones with carry-in
    start_op8(8'hFF, 8'h01, 1'b0);
    finish_op8("op_ff_01", 0);
    start_op8(8'hFF, 8'hFF, 1'b1);
    finish_op8("op_ff_ff_c", 0);

    // start pulsed at RUN cycle 3 must be ignored
    start_op8(8'h3C, 8'h0A, 1'b1);
    tick();
    tick();
    a8     = 8'h55;
    b8     = 8'h55;
    cin8   = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    finish_op8("ignore_start", 3);
    rose = 1'b0;
    repeat (12) begin
      tick();
      if (busy8) rose = 1'b1;
    end
    check("no_second_op", rose, 0);
    check("sum_hold_idle", sum8, 8'h47);

    // Partial-cycle reset at RUN cycle 4 abandons the addition
    start_op8(8'h11, 8'h22, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum",  sum8,  0);
    check("midrst_cout", cout8, 0);
    sb8.delete();
    #3 rst_n = 1'b1;
    rose = 1'b0;
    repeat (15) begin
      tick();
      if (done8 || busy8) rose = 1'b1;
    end
    check("no_done_after_rst", rose, 0);
    start_op8(8'h12, 8'h34, 1'b0);
    finish_op8("post_rst", 0);

    // Back-to-back: start held high across three operations
    n_acc     = 0;
    n_done    = 0;
    prev_busy = busy8;
    a8        = bb_a[0];
    b8        = bb_b[0];
    cin8      = 1'b0;
    start8    = 1'b1;
    for (int e = 1; e <= 60 && n_done < 3; e++) begin
      tick();
      if (busy8 && !prev_busy && n_acc < 3) begin
        acc[n_acc] = e;
        sb8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8));
        n_acc++;
        a8 = bb_a[n_acc];
        b8 = bb_b[n_acc];
      end
      if (done8 && n_done < 3) begin
        don[n_done] = e;
        if (sb8.size() > 0) begin
          ex = sb8.pop_front();
          check("b2b_sum", sum8, ex.sum);
          check("b2b_cout", cout8, ex.cout);
        end
        n_done++;
      end
      prev_busy = busy8;
    end
    start8 = 1'b0;
    check("b2b_ops_done", n_done, 3);
    if (n_done == 3) begin
      // accept, 8 RUN edges, DONE->IDLE edge, then the next accept
      check("b2b_accept_gap_1", acc[1] - acc[0], 10);
      check("b2b_accept_gap_2", acc[2] - acc[1], 10);
      check("b2b_latency_0", don[0] - acc[0], 8);
      check("b2b_latency_2", don[2] - acc[2], 8);
      check("b2b_done_gap", don[1] - don[0], 10);
    end
    tick();
    check("b2b_idle_after", busy8, 0);

    // WIDTH=1: full truth table, done one edge after each accept
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v      = 3'(i);
      a1     = v[2];
      b1     = v[1];
      cin1   = v[0];
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      sb1.push_back(model(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0]));
      check("w1_busy", busy1, 1);
      tick();
      check("w1_done", done1, 1);
      if (sb1.size() > 0) begin
        ex = sb1.pop_front();
        check("w1_sum", sum1, ex.sum);
        check("w1_cout", cout1, ex.cout);
      end
      tick();
      check("w1_done_low", done1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
